// File: rtl/ram_program_loader_pkg.sv
// loader_pkg: state encoding and default sizing shared by the program loader.
// No ports; imported by the loader top, its interface users and the bench.
package loader_pkg;

  localparam int NUM_BYTES_DEF   = 16;
  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_HI,
    WAIT_LO,
    WAIT_DONE,
    DONE,
    ERROR
  } state_e;

  // States in which the handshake timer runs.
  function automatic logic is_wait(state_e s);
    return (s == WAIT_HI) || (s == WAIT_LO) || (s == WAIT_DONE);
  endfunction

  // States in which host writes and start are accepted.
  function automatic logic is_rest(state_e s);
    return (s == IDLE) || (s == DONE) || (s == ERROR);
  endfunction

endpackage

// File: rtl/ram_program_loader_if.sv
// Host/CPU bundle for ram_program_loader. master = harness side, slave = loader.
// Host: wr_en/wr_addr/wr_data/start; CPU: cpu_ready/cpu_done in, prog_out/data_out
// out; status: busy/done/error/byte_cnt (+checksum when LOADER_CHECKSUM_EN).
interface ram_program_loader_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              start;
  logic              cpu_ready;
  logic              cpu_done;
  logic              prog_out;
  logic [7:0]        data_out;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   byte_cnt;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        checksum;

  modport master (
    output wr_en, wr_addr, wr_data, start,
    output cpu_ready, cpu_done,
    input  prog_out, data_out, busy, done,
    input  error, byte_cnt, checksum
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    input  cpu_ready, cpu_done,
    output prog_out, data_out, busy, done,
    output error, byte_cnt, checksum
  );
`else
  modport master (
    output wr_en, wr_addr, wr_data, start,
    output cpu_ready, cpu_done,
    input  prog_out, data_out, busy, done,
    input  error, byte_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    input  cpu_ready, cpu_done,
    output prog_out, data_out, busy, done,
    output error, byte_cnt
  );
`endif
endinterface

// File: rtl/ram_program_loader_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser, async active-high reset to 0.
// Ports: clk, rst, d (async input), q (synchronised, 2-cycle latency).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/ram_program_loader.sv
// ram_program_loader: streams a NUM_BYTES image into the CPU programming port.
// Ports: clk, rst (async, active high), bus (ram_program_loader_if.slave).
// Optional LOADER_CHECKSUM_EN adds bus.checksum, mod-256 sum of accepted bytes.
module ram_program_loader
  import loader_pkg::*;
#(
  parameter int NUM_BYTES   = NUM_BYTES_DEF,
  parameter int ADDR_W      = $clog2(NUM_BYTES),
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic                 clk,
  input logic                 rst,
  ram_program_loader_if.slave bus
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W:0] CNT_FULL =
    (ADDR_W + 1)'(NUM_BYTES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        image_q [NUM_BYTES];
  logic              rdy_s;
  logic              done_s;
  logic              busy;
  logic              tmo;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  sync_2ff u_sync_rdy (
    .clk (clk),
    .rst (rst),
    .d   (bus.cpu_ready),
    .q   (rdy_s)
  );

  sync_2ff u_sync_done (
    .clk (clk),
    .rst (rst),
    .d   (bus.cpu_done),
    .q   (done_s)
  );

  assign busy = !is_rest(state_q);
  assign tmo  = (timer_q == TMR_LAST);

  // Image is plain storage with no reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy) begin
      image_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (bus.start) begin
          state_d = ARM;
          idx_d   = '0;
          cnt_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      ARM: state_d = WAIT_HI;
      WAIT_HI: begin
        if (done_s)     state_d = DONE;
        else if (rdy_s) state_d = WAIT_LO;
        else if (tmo)   state_d = ERROR;
      end
      WAIT_LO: begin
        // Entered with rdy high, so low here is the falling edge.
        if (!rdy_s) begin
          cnt_d = cnt_q + 1'b1;
          idx_d = idx_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q + data_q;
`endif
          if (done_s)                state_d = DONE;
          else if (cnt_d == CNT_FULL) state_d = WAIT_DONE;
          else                        state_d = WAIT_HI;
        end else if (done_s) begin
          state_d = DONE;
        end else if (tmo) begin
          state_d = ERROR;
        end
      end
      WAIT_DONE: begin
        if (done_s)   state_d = DONE;
        else if (tmo) state_d = ERROR;
      end
      default: state_d = IDLE;
    endcase

    // Timer restarts on any state change.
    if (state_d != state_q)   timer_d = '0;
    else if (is_wait(state_q)) timer_d = timer_q + 1'b1;
    else                       timer_d = '0;

    unique case (state_d)
      WAIT_HI:           data_d = image_q[idx_d];
      IDLE, DONE, ERROR: data_d = '0;
      default:           data_d = data_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      data_q  <= data_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end

  assign bus.checksum = csum_q;
`endif

  assign bus.busy     = busy;
  assign bus.prog_out = busy;
  assign bus.done     = (state_q == DONE);
  assign bus.error    = (state_q == ERROR);
  assign bus.data_out = data_q;
  assign bus.byte_cnt = cnt_q;

endmodule

// File: tb/tb_ram_program_loader.sv
// tb_ram_program_loader: self-checking bench for ram_program_loader.
// Drives the host port and a behavioural CPU handshake model.
module tb_ram_program_loader;

  localparam int NB  = 16;
  localparam int AW  = 4;
  localparam int TMO = 255;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [7:0] img [NB];

  ram_program_loader_if #(.ADDR_W(AW)) bus ();

  ram_program_loader #(
    .NUM_BYTES   (NB),
    .ADDR_W      (AW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [AW-1:0] a,
                            input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
    img[a]      = d;
  endtask

  task automatic check_idle_zero(input string nm);
    n_tests++;
    if (bus.prog_out !== 1'b0 || bus.data_out !== 8'h00 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.error !== 1'b0 || bus.byte_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL %s got p=%b d=%h b=%b dn=%b e=%b c=%0d want all 0",
               nm, bus.prog_out, bus.data_out, bus.busy,
               bus.done, bus.error, bus.byte_cnt);
    end
  endtask

  // CPU model: accepts nb bytes then raises done. Optional host
  // disturbance per byte, optional reset while byte rst_at is up.
  task automatic cpu_load(input int nb, input bit disturb,
                          input int rst_at);
    int         w;
    logic [7:0] sum;
    sum = 8'h00;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_tests++;
    if (bus.prog_out !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL load_start prog_out=%b busy=%b want 1 1",
               bus.prog_out, bus.busy);
    end
    for (int k = 0; k < nb; k++) begin
      tick();
      tick();
      if (disturb) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'($urandom_range(0, NB - 1));
        bus.wr_data = 8'($urandom);
        bus.start   = 1'b1;
        tick();
        bus.wr_en   = 1'b0;
        bus.start   = 1'b0;
      end
      bus.cpu_ready = 1'b1;
      n_tests++;
      if (bus.data_out !== img[k]) begin
        n_fail++;
        $display("FAIL byte_%0d data_out=%h want %h",
                 k, bus.data_out, img[k]);
      end
      if (k == rst_at) begin
        #2 rst = 1'b1;
        #1 check_idle_zero("async_reset");
        bus.cpu_ready = 1'b0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        return;
      end
      repeat ($urandom_range(1, 3)) tick();
      bus.cpu_ready = 1'b0;
      sum = sum + img[k];
      w = 0;
      while (bus.byte_cnt !== 5'(k + 1) && w < 20) begin
        tick();
        w++;
      end
      n_tests++;
      if (bus.byte_cnt !== 5'(k + 1)) begin
        n_fail++;
        $display("FAIL accept_%0d byte_cnt=%0d want %0d",
                 k, bus.byte_cnt, k + 1);
      end
    end
    bus.cpu_done = 1'b1;
    w = 0;
    while (bus.done !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    n_tests++;
    if (bus.done !== 1'b1 || bus.error !== 1'b0 ||
        bus.busy !== 1'b0 || bus.prog_out !== 1'b0 ||
        bus.data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL load_end dn=%b e=%b b=%b p=%b d=%h want 1 0 0 0 00",
               bus.done, bus.error, bus.busy, bus.prog_out,
               bus.data_out);
    end
    n_tests++;
    if (bus.byte_cnt !== 5'(nb)) begin
      n_fail++;
      $display("FAIL final_count byte_cnt=%0d want %0d",
               bus.byte_cnt, nb);
    end
`ifdef LOADER_CHECKSUM_EN
    n_tests++;
    if (bus.checksum !== sum) begin
      n_fail++;
      $display("FAIL checksum got %h want %h", bus.checksum, sum);
    end
`endif
    bus.cpu_done = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    check_idle_zero("reset_state");
    rst = 1'b0;
    tick();
    check_idle_zero("after_reset");
  endtask

  task automatic test_full_load();
    for (int i = 0; i < NB; i++) host_write(AW'(i), 8'(8'h10 + i));
    cpu_load(NB, 1'b0, -1);
    for (int i = 0; i < NB; i++) host_write(AW'(i), 8'($urandom));
    cpu_load(NB, 1'b0, -1);
  endtask

  task automatic test_timeout();
    int n;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.error !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    // First tick after ARM enters WAIT_HI, then TMO cycles.
    n_tests++;
    if (n != TMO + 1) begin
      n_fail++;
      $display("FAIL timeout_cycles got %0d want %0d", n, TMO + 1);
    end
    n_tests++;
    if (bus.prog_out !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL timeout_outs p=%b b=%b dn=%b d=%h want 0 0 0 00",
               bus.prog_out, bus.busy, bus.done, bus.data_out);
    end
  endtask

  task automatic test_early_done();
    cpu_load(5, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    cpu_load(NB, 1'b0, 6);
    cpu_load(NB, 1'b0, -1);
  endtask

  task automatic test_write_during_load();
    cpu_load(NB, 1'b1, -1);
    for (int i = 0; i < 4; i++) begin
      host_write(AW'($urandom_range(0, NB - 1)), 8'($urandom));
    end
    cpu_load(NB, 1'b0, -1);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    for (int i = 0; i < NB; i++) host_write(AW'(i), 8'hFF);
    cpu_load(NB, 1'b0, -1);
    n_tests++;
    if (bus.checksum !== 8'hF0) begin
      n_fail++;
      $display("FAIL checksum_ff got %h want f0", bus.checksum);
    end
  endtask
`endif

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.start     = 1'b0;
    bus.cpu_ready = 1'b0;
    bus.cpu_done  = 1'b0;
    test_reset();
    test_full_load();
    test_timeout();
    test_early_done();
    test_reset_mid();
    test_write_during_load();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
